lcd_timing_driver: RTL

Pixel-timing master for the LCD/VGA output path. Generates horizontal/vertical counters, issues pixel-coordinate requests (`lcd_xpos`/`lcd_ypos`) to the pixel source `DATA_LAT` cycles ahead of display, and takes back the returned 24-bit `lcd_data`. Drives registered sync, data-enable and RGB pins to the panel or DAC. Defaults target 640x480@60 Hz with a 25 MHz pixel clock.

---
 rtl/lcd_timing_driver.sv | 135 +++++++++++++
 1 files changed

// File: rtl/lcd_timing_driver.sv
// rtl/lcd_timing_driver.sv - LCD/VGA pixel timing master with coordinate requests; colour bars under LCD_TEST_PATTERN_EN
module lcd_timing_driver #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_DISP   = 640,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_DISP   = 480,
  parameter int V_FRONT  = 10,
  parameter int DATA_LAT = 1
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic [23:0] lcd_data,
`ifdef LCD_TEST_PATTERN_EN
  input  logic        test_en,
`endif
  output logic        lcd_request,
  output logic [10:0] lcd_xpos,
  output logic [10:0] lcd_ypos,
  output logic        lcd_hs,
  output logic        lcd_vs,
  output logic        lcd_de,
  output logic [23:0] lcd_rgb,
  output logic        lcd_frame_start
);

  // All timing arithmetic is done at 11 bits, matching the counters.
  localparam logic [10:0] L_H_SYNC  = 11'(H_SYNC);
  localparam logic [10:0] L_V_SYNC  = 11'(V_SYNC);
  localparam logic [10:0] L_H_TOTAL = 11'(H_SYNC + H_BACK + H_DISP + H_FRONT);
  localparam logic [10:0] L_V_TOTAL = 11'(V_SYNC + V_BACK + V_DISP + V_FRONT);
  localparam logic [10:0] L_H_START = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] L_H_END   = 11'(H_SYNC + H_BACK + H_DISP);
  localparam logic [10:0] L_V_START = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] L_V_END   = 11'(V_SYNC + V_BACK + V_DISP);
  // Requests lead the displayed pixel by the source read latency.
  localparam logic [10:0] L_REQ_BEG = 11'(H_SYNC + H_BACK - DATA_LAT);
  localparam logic [10:0] L_REQ_END = 11'(H_SYNC + H_BACK + H_DISP - DATA_LAT);

  logic [10:0] r_hcnt;
  logic [10:0] r_vcnt;
  logic        r_hs;
  logic        r_vs;
  logic        r_de;
  logic [23:0] r_rgb;
  logic        r_frame_start;

  logic        w_h_last;
  logic        w_v_last;
  logic        w_v_act;
  logic        w_req_win;
  logic        w_de_int;
  logic [23:0] w_pix;

  assign w_h_last  = (r_hcnt == L_H_TOTAL - 11'd1);
  assign w_v_last  = (r_vcnt == L_V_TOTAL - 11'd1);
  assign w_v_act   = (r_vcnt >= L_V_START) && (r_vcnt < L_V_END);
  assign w_req_win = w_v_act && (r_hcnt >= L_REQ_BEG) && (r_hcnt < L_REQ_END);
  assign w_de_int  = w_v_act && (r_hcnt >= L_H_START) && (r_hcnt < L_H_END);

  assign lcd_request = w_req_win;
  assign lcd_xpos    = w_req_win ? (r_hcnt - L_REQ_BEG) : 11'd0;
  assign lcd_ypos    = w_req_win ? (r_vcnt - L_V_START) : 11'd0;

`ifdef LCD_TEST_PATTERN_EN
  localparam int          BAR_W   = (H_DISP / 8 > 0) ? (H_DISP / 8) : 1;
  localparam logic [10:0] L_BAR_W = 11'(BAR_W);

  logic [10:0] w_col;
  logic [10:0] w_bar;
  logic [23:0] w_bar_rgb;

  // Bar index comes from the display column itself, so it lines up with DE regardless of source latency.
  assign w_col = r_hcnt - L_H_START;
  assign w_bar = w_col / L_BAR_W;

  // Map bar index to colour: white, yellow, cyan, green, magenta, red, blue, black.
  always_comb begin
    w_bar_rgb = 24'h000000;
    case (w_bar)
      11'd0:   w_bar_rgb = 24'hFFFFFF;
      11'd1:   w_bar_rgb = 24'hFFFF00;
      11'd2:   w_bar_rgb = 24'h00FFFF;
      11'd3:   w_bar_rgb = 24'h00FF00;
      11'd4:   w_bar_rgb = 24'hFF00FF;
      11'd5:   w_bar_rgb = 24'hFF0000;
      11'd6:   w_bar_rgb = 24'h0000FF;
      default: w_bar_rgb = 24'h000000;
    endcase
  end

  assign w_pix = test_en ? w_bar_rgb : lcd_data;
`else
  assign w_pix = lcd_data;
`endif

  // Horizontal and vertical counters; both wrap together at the frame end.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_hcnt <= 11'd0;
      r_vcnt <= 11'd0;
    end else if (w_h_last) begin
      r_hcnt <= 11'd0;
      r_vcnt <= w_v_last ? 11'd0 : (r_vcnt + 11'd1);
    end else begin
      r_hcnt <= r_hcnt + 11'd1;
    end
  end

  // Panel pins, registered one clock behind the counters; RGB is blanked outside the display window.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_hs          <= 1'b1;
      r_vs          <= 1'b1;
      r_de          <= 1'b0;
      r_rgb         <= 24'd0;
      r_frame_start <= 1'b0;
    end else begin
      r_hs          <= !(r_hcnt < L_H_SYNC);
      r_vs          <= !(r_vcnt < L_V_SYNC);
      r_de          <= w_de_int;
      r_rgb         <= w_de_int ? w_pix : 24'd0;
      r_frame_start <= (r_hcnt == 11'd0) && (r_vcnt == 11'd0);
    end
  end

  assign lcd_hs          = r_hs;
  assign lcd_vs          = r_vs;
  assign lcd_de          = r_de;
  assign lcd_rgb         = r_rgb;
  assign lcd_frame_start = r_frame_start;

endmodule
